div_unit: RTL and testbench

//   Iterative RV32M divider (DIV/DIVU/REM/REMU) in the EX stage. It produces the stall

---
 rtl/div_unit_if.sv | 29 ++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// +----------------------------------------------------------------------+
// | div_unit_if : EX-stage request/response bundle of the divider. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic            flush_i;
   logic            stall_req_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, op_i, dividend_i, divisor_i, flush_i,
      input  stall_req_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, flush_i,
      output stall_req_o, done_o, result_o
   );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// +----------------------------------------------------------------------+
// | div_unit : restoring radix-2 RV32M DIV/DIVU/REM/REMU. Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module div_unit #(
   parameter int XLEN = 32
) (
   input  wire logic      clk,
   input  wire logic      rst,
   div_unit_if.slave      bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic            sel_rem;
   logic            neg_q;
   logic            neg_r;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] result;
   logic            done;

   logic            signed_op;
   logic            sa;
   logic            sb;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic            div_zero;
   logic            ovf;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic            ge;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   assign signed_op = ~bus.op_i[0];
   assign sa        = signed_op & bus.dividend_i[XLEN-1];
   assign sb        = signed_op & bus.divisor_i[XLEN-1];
   assign abs_a     = sa ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
   assign abs_b     = sb ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
   assign div_zero  = (bus.divisor_i == '0);
   assign ovf       = signed_op && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.divisor_i == '1);

   // Partial remainder needs one extra bit: it can reach 2*divisor-1 before the compare.
   assign shifted   = {rem, quo[XLEN-1]};
   assign diff      = shifted - {1'b0, dvs};
   assign ge        = ~diff[XLEN];
   assign rem_next  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign quo_next  = {quo[XLEN-2:0], ge};
   assign q_fix     = neg_q ? (~quo_next + 1'b1) : quo_next;
   assign r_fix     = neg_r ? (~rem_next + 1'b1) : rem_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel_rem <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         result  <= '0;
         done    <= 1'b0;
      end else if (bus.flush_i) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.start_i) begin
                  sel_rem <= bus.op_i[1];
                  if (div_zero) begin
                     result <= bus.op_i[1] ? bus.dividend_i : '1;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else if (ovf) begin
                     result <= bus.op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     quo   <= abs_a;
                     dvs   <= abs_b;
                     rem   <= '0;
                     cnt   <= CW'(XLEN-1);
                     neg_q <= sa ^ sb;
                     neg_r <= sa;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result <= sel_rem ? r_fix : q_fix;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Stall drops in DONE so the instruction leaves EX in that same cycle.
   assign bus.stall_req_o = ((state == IDLE) && bus.start_i && !bus.flush_i) || (state == CALC);
   assign bus.done_o      = done;
   assign bus.result_o    = result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// +----------------------------------------------------------------------+
// | tb_div_unit : vector table, random ops vs. arithmetic model. Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_unit_if #(.XLEN(32)) dif ();

   div_unit #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return 32'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   // Holds start_i high until done_o; scrambles operands once accepted.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_cyc, output int stalls);
      @(posedge clk); #1;
      dif.start_i = 1'b1;
      dif.op_i = op;
      dif.dividend_i = a;
      dif.divisor_i = b;
      done_cyc = -1;
      stalls = 0;
      res = 32'hDEAD_BEEF;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (dif.stall_req_o) stalls++;
         if (dif.done_o) begin
            done_cyc = c;
            res = dif.result_o;
            break;
         end
         if (c >= 1) begin
            dif.op_i = 2'($urandom_range(0, 3));
            dif.dividend_i = $urandom;
            dif.divisor_i = $urandom;
         end
      end
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
      logic [31:0] res;
      int dc, st;
      run_op(op, a, b, res, dc, st);
      chk({tag, "_result"}, res, exp);
      chk({tag, "_latency"}, 32'(dc), 32'(lat));
      chk({tag, "_stalls"}, 32'(st), (lat == 1) ? 32'd1 : 32'd33);
   endtask

   vec_t vecs[14];

   initial begin
      logic [31:0] a, b;
      logic [1:0]  op;
      int          dones;

      vecs[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, 33};
      vecs[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, 33};
      vecs[2]  = '{2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33};
      vecs[3]  = '{2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33};
      vecs[4]  = '{2'b10, 32'd7, -32'sd2, 32'd1, 33};
      vecs[5]  = '{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
      vecs[6]  = '{2'b11, 32'h1234, 32'd0, 32'h1234, 1};
      vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
      vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33};
      vecs[10] = '{2'b01, 32'd0, 32'd5, 32'd0, 33};
      vecs[11] = '{2'b00, -32'sd100, -32'sd7, 32'd14, 33};
      vecs[12] = '{2'b10, -32'sd100, -32'sd7, 32'hFFFF_FFFE, 33};
      vecs[13] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};

      dif.start_i = 1'b0;
      dif.op_i = 2'b00;
      dif.dividend_i = '0;
      dif.divisor_i = '0;
      dif.flush_i = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", 32'(dif.stall_req_o), 32'd0);
      chk("reset_done", 32'(dif.done_o), 32'd0);
      chk("reset_result", dif.result_o, 32'd0);

      for (int i = 0; i < 14; i++)
         check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Flush mid-CALC: no done, result keeps the previous value.
      check_op("pre_flush", 2'b01, 32'd77, 32'd7, 32'd11, 33);
      @(posedge clk); #1;
      dif.start_i = 1'b1; dif.op_i = 2'b01; dif.dividend_i = 32'd1000; dif.divisor_i = 32'd3;
      repeat (10) @(posedge clk);
      #1 dif.flush_i = 1'b1;
      @(posedge clk); #1;
      dif.flush_i = 1'b0; dif.start_i = 1'b0;
      @(negedge clk);
      chk("flush_stall", 32'(dif.stall_req_o), 32'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.done_o) dones++;
      end
      chk("flush_no_done", 32'(dones), 32'd0);
      chk("flush_result_kept", dif.result_o, 32'd11);
      check_op("after_flush", 2'b01, 32'd9, 32'd3, 32'd3, 33);

      // Flush together with start in IDLE must not begin an op.
      @(posedge clk); #1;
      dif.start_i = 1'b1; dif.flush_i = 1'b1; dif.op_i = 2'b01; dif.dividend_i = 32'd50; dif.divisor_i = 32'd5;
      @(negedge clk);
      chk("flush_start_stall", 32'(dif.stall_req_o), 32'd0);
      @(posedge clk); #1;
      dif.start_i = 1'b0; dif.flush_i = 1'b0;
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (dif.done_o || dif.stall_req_o) dones++;
      end
      chk("flush_start_idle", 32'(dones), 32'd0);

      // Reset mid-CALC clears every output.
      @(posedge clk); #1;
      dif.start_i = 1'b1; dif.op_i = 2'b01; dif.dividend_i = 32'd1000; dif.divisor_i = 32'd3;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1; dif.start_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", 32'(dif.stall_req_o), 32'd0);
      chk("rst_done", 32'(dif.done_o), 32'd0);
      chk("rst_result", dif.result_o, 32'd0);
      check_op("after_rst", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       begin a = $urandom; b = 32'd0; end
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       begin a = $urandom_range(0, 500) - 250; b = $urandom_range(0, 40) - 20; end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         check_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), is_special(op, a, b) ? 1 : 33);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
